// File: rtl/router_1xn_if.sv
// Packet-stream and CSR bundle for router_1xn.
// The master drives the input stream and CSR strobes; the slave is the router itself.
interface router_1xn_if #(
    parameter int NUM_PORTS = 4
);
    logic [7:0]             dut_inp;
    logic                   inp_valid;
    logic [8*NUM_PORTS-1:0] dut_outp;
    logic [NUM_PORTS-1:0]   outp_valid;
    logic                   busy;
    logic                   error;
    logic                   wr;
    logic                   rd;
    logic [7:0]             addr;
    logic [31:0]            wdata;
    logic [31:0]            rdata;

    modport master (
        output dut_inp, inp_valid, wr, rd, addr, wdata,
        input  dut_outp, outp_valid, busy, error, rdata
    );

    modport slave (
        input  dut_inp, inp_valid, wr, rd, addr, wdata,
        output dut_outp, outp_valid, busy, error, rdata
    );
endinterface

// File: rtl/router_1xn.sv
// 1-to-N packet router: buffers a DA/LEN/payload/CSUM packet, validates it,
// then replays it byte by byte on the selected output port. CSR block holds counters and port mask.
module router_1xn #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_LEN   = 32
) (
    input  logic         clk,
    input  logic         reset,
    router_1xn_if.slave  bus
);

    localparam int         BUF_LEN = MAX_LEN + 3;
    localparam int         IDX_W   = $clog2(BUF_LEN);
    localparam logic [7:0] NP8     = 8'(NUM_PORTS);
    localparam logic [7:0] ML8     = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_FWD     = 3'd4;

    localparam logic [7:0] ADDR_RX   = 8'h00;
    localparam logic [7:0] ADDR_GOOD = 8'h04;
    localparam logic [7:0] ADDR_ERR  = 8'h08;
    localparam logic [7:0] ADDR_DROP = 8'h0C;
    localparam logic [7:0] ADDR_CTRL = 8'h10;
    localparam logic [7:0] ADDR_INFO = 8'h14;

    logic [2:0]           state;
    logic [7:0]           pkt_buf [BUF_LEN];
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [7:0]           da_reg;
    logic [7:0]           pkt_len;
    logic [7:0]           pay_left;
    logic [7:0]           fwd_left;
    logic [7:0]           xor_acc;
    logic                 len_bad;
    logic [7:0]           out_byte;
    logic [NUM_PORTS-1:0] out_sel;
    logic                 error_q;

    logic [NUM_PORTS-1:0] ctrl_mask;
    logic [31:0]          rx_cnt;
    logic [31:0]          good_cnt;
    logic [31:0]          err_cnt;
    logic [31:0]          drop_cnt;
    logic [31:0]          rdata_q;
    logic [31:0]          csr_val;

    logic                 byte_acc;
    logic                 byte_drop;
    logic                 pkt_done;
    logic                 pkt_ok;
    logic                 da_en;
    logic [NUM_PORTS-1:0] da_onehot;
    logic                 unused_wdata;

    assign byte_acc     = bus.inp_valid && (state != S_FWD);
    assign byte_drop    = bus.inp_valid && (state == S_FWD);
    assign pkt_done     = byte_acc && (state == S_CSUM);
    assign unused_wdata = ^bus.wdata;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Decode DA into a port select and its enable bit; out-of-range DA selects nothing.
    always_comb begin
        da_onehot = '0;
        da_en     = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (da_reg == 8'(p)) begin
                da_onehot[p] = 1'b1;
                da_en        = ctrl_mask[p];
            end
        end
    end

    assign pkt_ok = !len_bad && ((xor_acc ^ bus.dut_inp) == 8'h00) && (da_reg < NP8) && da_en;

    always_ff @(posedge clk) begin
        if (byte_acc) begin
            pkt_buf[wr_idx] <= bus.dut_inp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            da_reg   <= '0;
            pkt_len  <= '0;
            pay_left <= '0;
            fwd_left <= '0;
            xor_acc  <= '0;
            len_bad  <= 1'b0;
            out_byte <= '0;
            out_sel  <= '0;
            error_q  <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.inp_valid) begin
                        da_reg  <= bus.dut_inp;
                        xor_acc <= bus.dut_inp;
                        wr_idx  <= IDX_W'(1);
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.inp_valid) begin
                        pkt_len  <= bus.dut_inp;
                        pay_left <= bus.dut_inp;
                        xor_acc  <= xor_acc ^ bus.dut_inp;
                        wr_idx   <= wr_idx + 1'b1;
                        // A bad length skips the payload; the next byte is taken as CSUM.
                        if ((bus.dut_inp == 8'h00) || (bus.dut_inp > ML8)) begin
                            len_bad <= 1'b1;
                            state   <= S_CSUM;
                        end else begin
                            len_bad <= 1'b0;
                            state   <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bus.inp_valid) begin
                        xor_acc  <= xor_acc ^ bus.dut_inp;
                        wr_idx   <= wr_idx + 1'b1;
                        pay_left <= pay_left - 8'd1;
                        if (pay_left == 8'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (bus.inp_valid) begin
                        wr_idx <= '0;
                        if (pkt_ok) begin
                            state    <= S_FWD;
                            out_byte <= da_reg;
                            out_sel  <= da_onehot;
                            rd_idx   <= IDX_W'(1);
                            fwd_left <= pkt_len + 8'd2;
                        end else begin
                            state   <= S_IDLE;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_FWD: begin
                    if (fwd_left == 8'd0) begin
                        state    <= S_IDLE;
                        out_sel  <= '0;
                        out_byte <= '0;
                        rd_idx   <= '0;
                    end else begin
                        out_byte <= pkt_buf[rd_idx];
                        rd_idx   <= rd_idx + 1'b1;
                        fwd_left <= fwd_left - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        csr_val = '0;
        case (bus.addr)
            ADDR_RX:   csr_val = rx_cnt;
            ADDR_GOOD: csr_val = good_cnt;
            ADDR_ERR:  csr_val = err_cnt;
            ADDR_DROP: csr_val = drop_cnt;
            ADDR_CTRL: csr_val = 32'(ctrl_mask);
            ADDR_INFO: csr_val = {16'h0000, NP8, ML8};
            default:   csr_val = '0;
        endcase
    end

    // A write to a counter address clears it even if an increment lands in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt    <= '0;
            good_cnt  <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
            ctrl_mask <= '1;
            rdata_q   <= '0;
        end else begin
            if (bus.wr && bus.addr == ADDR_RX)        rx_cnt <= '0;
            else if (pkt_done)                        rx_cnt <= sat_inc(rx_cnt);

            if (bus.wr && bus.addr == ADDR_GOOD)      good_cnt <= '0;
            else if (pkt_done && pkt_ok)              good_cnt <= sat_inc(good_cnt);

            if (bus.wr && bus.addr == ADDR_ERR)       err_cnt <= '0;
            else if (pkt_done && !pkt_ok)             err_cnt <= sat_inc(err_cnt);

            if (bus.wr && bus.addr == ADDR_DROP)      drop_cnt <= '0;
            else if (byte_drop)                       drop_cnt <= sat_inc(drop_cnt);

            if (bus.wr && bus.addr == ADDR_CTRL)      ctrl_mask <= bus.wdata[NUM_PORTS-1:0];

            if (bus.rd && !bus.wr)                    rdata_q <= csr_val;
        end
    end

    always_comb begin
        bus.dut_outp = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_sel[p]) begin
                bus.dut_outp[8*p +: 8] = out_byte;
            end
        end
    end

    assign bus.outp_valid = out_sel;
    assign bus.busy       = (state == S_FWD);
    assign bus.error      = error_q;
    assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: directed scenarios plus random packets, checked every cycle
// against a queue-based packet model of the router.
module tb_router_1xn;

    localparam int NUM_PORTS = 4;
    localparam int MAX_LEN   = 32;

    logic clk = 1'b0;
    logic reset;

    router_1xn_if #(.NUM_PORTS(NUM_PORTS)) bus ();

    router_1xn #(.NUM_PORTS(NUM_PORTS), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0]  pkt_q[$];
    logic [7:0]  fwd_q[$];
    logic [7:0]  tx_q[$];
    int          fwd_port;
    logic [31:0] m_rx, m_good, m_err, m_drop, m_rdata;
    logic [3:0]  m_ctrl;
    logic        m_error;
    logic [7:0]  addr_tab [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] modelCsr(input logic [7:0] a);
        case (a)
            8'h00:   return m_rx;
            8'h04:   return m_good;
            8'h08:   return m_err;
            8'h0C:   return m_drop;
            8'h10:   return {28'h0, m_ctrl};
            8'h14:   return {16'h0, 8'(NUM_PORTS), 8'(MAX_LEN)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit packetComplete();
        int n = pkt_q.size();
        int len;
        if (n < 3) return 1'b0;
        len = int'(pkt_q[1]);
        if (len == 0 || len > MAX_LEN) return (n == 3);
        return (n == len + 3);
    endfunction

    function automatic bit packetGood();
        logic [7:0] x = 8'h00;
        int len = int'(pkt_q[1]);
        int da  = int'(pkt_q[0]);
        foreach (pkt_q[i]) x ^= pkt_q[i];
        if (len == 0 || len > MAX_LEN) return 1'b0;
        if (x != 8'h00) return 1'b0;
        if (da >= NUM_PORTS) return 1'b0;
        return m_ctrl[da];
    endfunction

    task automatic modelReset();
        pkt_q.delete();
        fwd_q.delete();
        fwd_port = 0;
        m_rx = 0; m_good = 0; m_err = 0; m_drop = 0; m_rdata = 0;
        m_ctrl = 4'hF;
        m_error = 1'b0;
    endtask

    // One clock edge of the reference: replay queue advances, or the byte joins the packet.
    task automatic modelStep();
        logic [31:0] csr_before = modelCsr(bus.addr);
        bit rx_inc = 0, good_inc = 0, err_inc = 0, drop_inc = 0;
        m_error = 1'b0;
        if (fwd_q.size() > 0) begin
            void'(fwd_q.pop_front());
            if (bus.inp_valid) drop_inc = 1;
        end else if (bus.inp_valid) begin
            pkt_q.push_back(bus.dut_inp);
            if (packetComplete()) begin
                rx_inc = 1;
                if (packetGood()) begin
                    good_inc = 1;
                    fwd_q    = pkt_q;
                    fwd_port = int'(pkt_q[0]);
                end else begin
                    err_inc = 1;
                    m_error = 1'b1;
                end
                pkt_q.delete();
            end
        end
        if (bus.wr && bus.addr == 8'h00) m_rx = 0;   else if (rx_inc)   m_rx   = sat(m_rx);
        if (bus.wr && bus.addr == 8'h04) m_good = 0; else if (good_inc) m_good = sat(m_good);
        if (bus.wr && bus.addr == 8'h08) m_err = 0;  else if (err_inc)  m_err  = sat(m_err);
        if (bus.wr && bus.addr == 8'h0C) m_drop = 0; else if (drop_inc) m_drop = sat(m_drop);
        if (bus.wr && bus.addr == 8'h10) m_ctrl = bus.wdata[3:0];
        if (bus.rd && !bus.wr) m_rdata = csr_before;
    endtask

    task automatic checkAll();
        logic [31:0] ev = 0;
        logic [31:0] eo = 0;
        if (fwd_q.size() > 0) begin
            ev[fwd_port]         = 1'b1;
            eo[8*fwd_port +: 8]  = fwd_q[0];
        end
        checkOutput("busy",       32'(bus.busy),       32'(fwd_q.size() > 0));
        checkOutput("error",      32'(bus.error),      32'(m_error));
        checkOutput("outp_valid", 32'(bus.outp_valid), ev);
        checkOutput("dut_outp",   bus.dut_outp,        eo);
        checkOutput("rdata",      bus.rdata,           m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit w, input bit r,
                                 input logic [7:0] a, input logic [31:0] wd);
        bus.inp_valid = v;
        bus.dut_inp   = d;
        bus.wr        = w;
        bus.rd        = r;
        bus.addr      = a;
        bus.wdata     = wd;
        tick();
        bus.inp_valid = 1'b0;
        bus.dut_inp   = 8'h00;
        bus.wr        = 1'b0;
        bus.rd        = 1'b0;
        bus.addr      = 8'h00;
        bus.wdata     = 32'h0;
    endtask

    task automatic idleTick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic sendTx();
        foreach (tx_q[i]) applyStimulus(1'b1, tx_q[i], 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic waitIdle();
        while (fwd_q.size() > 0) idleTick();
    endtask

    task automatic csrWrite(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, a, d);
    endtask

    task automatic csrRead(input logic [7:0] a, input logic [31:0] want);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, a, 32'h0);
        checkOutput($sformatf("csr_%02h", a), bus.rdata, want);
    endtask

    task automatic clearCounters();
        csrWrite(8'h00, 32'h0);
        csrWrite(8'h04, 32'h0);
        csrWrite(8'h08, 32'h0);
        csrWrite(8'h0C, 32'h0);
    endtask

    task automatic randomCycle(input bit v, input logic [7:0] d);
        bit          w  = ($urandom_range(0, 15) == 0);
        bit          r  = ($urandom_range(0, 3) == 0);
        logic [7:0]  a  = addr_tab[$urandom_range(0, 7)];
        logic [31:0] wd = ($urandom_range(0, 1) == 1) ? 32'hF : $urandom;
        applyStimulus(v, d, w, r, a, wd);
    endtask

    task automatic buildRandomPacket();
        logic [7:0] da, len, cs;
        int r;
        tx_q.delete();
        da = 8'($urandom_range(0, NUM_PORTS + 1));
        r  = $urandom_range(0, 19);
        if (r == 0)      len = 8'h00;
        else if (r == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
        else if (r == 2) len = 8'(MAX_LEN);
        else             len = 8'($urandom_range(1, 8));
        tx_q.push_back(da);
        tx_q.push_back(len);
        if (len != 8'h00 && int'(len) <= MAX_LEN)
            for (int i = 0; i < int'(len); i++) tx_q.push_back(8'($urandom));
        cs = 8'h00;
        foreach (tx_q[i]) cs ^= tx_q[i];
        if ($urandom_range(0, 9) == 0) cs ^= 8'($urandom_range(1, 255));
        tx_q.push_back(cs);
    endtask

    initial begin
        reset         = 1'b1;
        bus.inp_valid = 1'b0;
        bus.dut_inp   = 8'h00;
        bus.wr        = 1'b0;
        bus.rd        = 1'b0;
        bus.addr      = 8'h00;
        bus.wdata     = 32'h0;
        modelReset();
        tick();
        tick();
        reset = 1'b0;
        idleTick();

        $display("[TB] good packet to port 2");
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
        sendTx();
        for (int i = 0; i < 6; i++) begin
            checkOutput("p2_data",  32'(bus.dut_outp[23:16]), 32'(tx_q[i]));
            checkOutput("p2_valid", 32'(bus.outp_valid),      32'h4);
            idleTick();
        end
        checkOutput("p2_busy_end", 32'(bus.busy), 32'h0);
        csrRead(8'h04, 32'd1);

        $display("[TB] bad checksum");
        clearCounters();
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        sendTx();
        checkOutput("csum_err_pulse", 32'(bus.error), 32'h1);
        checkOutput("csum_no_valid",  32'(bus.outp_valid), 32'h0);
        idleTick();
        checkOutput("csum_err_end", 32'(bus.error), 32'h0);
        csrRead(8'h08, 32'd1);
        csrRead(8'h00, 32'd1);

        $display("[TB] bad DA and disabled port");
        clearCounters();
        tx_q = '{8'h05, 8'h01, 8'hAA, 8'hAE};
        sendTx();
        checkOutput("da_err_pulse", 32'(bus.error), 32'h1);
        csrRead(8'h08, 32'd1);
        csrWrite(8'h10, 32'hB);
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
        sendTx();
        checkOutput("mask_err_pulse", 32'(bus.error), 32'h1);
        csrRead(8'h10, 32'hB);
        csrRead(8'h08, 32'd2);
        csrWrite(8'h10, 32'hF);

        $display("[TB] length boundaries");
        clearCounters();
        tx_q = '{8'h01, 8'h00, 8'h01};
        sendTx();
        checkOutput("len0_err", 32'(bus.error), 32'h1);
        tx_q = '{8'h01, 8'h21, 8'h20};
        sendTx();
        checkOutput("lenmax_err", 32'(bus.error), 32'h1);
        csrRead(8'h08, 32'd2);

        $display("[TB] drops while forwarding");
        clearCounters();
        tx_q = '{8'h01, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD2};
        sendTx();
        for (int i = 0; i < 6; i++) begin
            checkOutput("fwd_p1", 32'(bus.dut_outp[15:8]), 32'(tx_q[i]));
            applyStimulus(i < 3, 8'h55, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        waitIdle();
        csrRead(8'h0C, 32'd3);
        csrRead(8'h04, 32'd1);

        $display("[TB] reset during forwarding");
        tx_q = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
        sendTx();
        idleTick();
        idleTick();
        checkOutput("pre_rst_byte", 32'(bus.dut_outp[23:16]), 32'h11);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(bus.outp_valid), 32'h0);
        checkOutput("rst_outp",  bus.dut_outp,        32'h0);
        checkOutput("rst_busy",  32'(bus.busy),       32'h0);
        modelReset();
        tick();
        reset = 1'b0;
        idleTick();
        checkOutput("post_rst_valid", 32'(bus.outp_valid), 32'h0);
        csrRead(8'h00, 32'h0);
        csrRead(8'h04, 32'h0);
        csrRead(8'h08, 32'h0);
        csrRead(8'h0C, 32'h0);
        csrRead(8'h10, 32'hF);
        csrRead(8'h14, 32'h0000_0420);
        csrRead(8'h18, 32'h0);

        $display("[TB] clear versus increment, write with read");
        tx_q = '{8'h03, 8'h01, 8'h7E, 8'h7C};
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, tx_q[i], 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b1, tx_q[3], 1'b1, 1'b0, 8'h00, 32'h0);
        waitIdle();
        csrRead(8'h00, 32'h0);
        csrRead(8'h04, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'h5);
        checkOutput("wr_rd_hold", bus.rdata, 32'd1);
        csrRead(8'h10, 32'h5);
        csrWrite(8'h10, 32'hF);

        $display("[TB] random packets");
        for (int k = 0; k < 250; k++) begin
            buildRandomPacket();
            for (int i = 0; i < tx_q.size(); i++) begin
                while (fwd_q.size() > 0) randomCycle($urandom_range(0, 3) == 0, 8'($urandom));
                if ($urandom_range(0, 3) == 0) randomCycle(1'b0, 8'h00);
                randomCycle(1'b1, tx_q[i]);
            end
        end
        waitIdle();
        repeat (4) idleTick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/router_1xn.md
ROUTER_1XN -- requirements
Module: router_1xn

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of output ports (legal 2..16).
REQ-002 Parameter MAX_LEN, default 32, maximum payload bytes per packet (legal 1..252).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  reset; asynchronous, active-high.
REQ-005 dut_inp  input  8  packet byte stream.
REQ-006 inp_valid  input  1  dut_inp holds a valid byte this cycle.
REQ-007 dut_outp  output  8*NUM_PORTS  per-port output byte; port p occupies bits [8p+7:8p].
REQ-008 outp_valid  output  NUM_PORTS  per-port output byte valid.
REQ-009 busy  output  1  forwarding in progress; input bytes are not accepted.
REQ-010 error  output  1  one-cycle pulse on a rejected packet.
REQ-011 wr, rd  input  1 each  CSR write and read strobes.
REQ-012 addr  input  8  CSR byte address.
REQ-013 wdata  input  32  CSR write data.
REQ-014 rdata  output  32  CSR read data.

Function
REQ-015 The packet format SHALL be: DA byte, then LEN byte (payload count), then LEN payload bytes, then CSUM byte. CSUM equals the XOR of all preceding bytes of the packet.
REQ-016 A byte SHALL be accepted on a posedge with inp_valid=1 and busy=0. Gaps where inp_valid=0 SHALL be allowed anywhere within a packet.
REQ-017 The receive FSM SHALL use states IDLE->LEN->PAYLOAD->CSUM->(FWD or IDLE).
- PAYLOAD SHALL be skipped when LEN=0.
- The packet SHALL be stored in an internal buffer of MAX_LEN+3 bytes.
REQ-018 The packet SHALL be rejected when any of the following holds: DA>=NUM_PORTS; LEN=0; LEN>MAX_LEN; CSUM mismatch; the ctrl enable bit for DA is 0.
- LEN=0 or LEN>MAX_LEN SHALL be detected in the LEN state, and the FSM SHALL then consume exactly one further byte as CSUM before rejecting.
REQ-019 On reject:
- error=1 for exactly the cycle after the CSUM byte is accepted;
- the buffer is discarded and the FSM returns to IDLE;
- busy stays 0.
REQ-020 On accept, with CSUM accepted at cycle T:
- busy=1 from T+1 through T+LEN+3;
- outp_valid[DA]=1 for cycles T+1..T+LEN+3, carrying DA, LEN, payload, CSUM in order;
- all other outp_valid bits stay 0.
REQ-021 Each byte presented with inp_valid=1 while busy=1 SHALL be discarded and SHALL increment DROP_CNT.
REQ-022 dut_outp of ports with outp_valid=0 SHALL be 0x00.
REQ-023 CSR map (addresses not listed read 0):
- 0x00 RX_CNT: packets completed, good or bad.
- 0x04 GOOD_CNT.
- 0x08 ERR_CNT.
- 0x0C DROP_CNT.
- 0x10 CTRL: bits[NUM_PORTS-1:0] port enable mask, read/write.
- 0x14 INFO: read-only, {16'h0, NUM_PORTS[7:0], MAX_LEN[7:0]}.
REQ-024 Counters SHALL be 32 bits, saturating at 0xFFFFFFFF. Any CSR write to a counter address SHALL clear that counter; the clear wins over a same-cycle increment.
REQ-025 CSR reads SHALL be registered: rdata is valid the cycle after rd=1 and holds its value until the next read.
REQ-026 When wr=1 and rd=1 in the same cycle, the write SHALL occur and rdata SHALL hold its value.
REQ-027 CTRL changes SHALL take effect for packets whose CSUM is accepted after the write; an in-progress FWD SHALL be unaffected.
REQ-028 DA, LEN and CSUM SHALL be checked with 8-bit unsigned arithmetic.

Reset
REQ-029 While reset=1, and immediately on its assertion:
- FSM=IDLE, buffer discarded;
- outp_valid=0, dut_outp=0, busy=0, error=0, rdata=0;
- all counters 0;
- CTRL mask all ones.
REQ-030 Reset asserted mid-receive or mid-FWD SHALL abort the packet with no partial output after reset release and no counter update.

Verification
REQ-031 NUM_PORTS=4; input 02,03,11,22,33,01 -> port 2 outputs 02,03,11,22,33,01 on 6 consecutive cycles; outp_valid=4'b0100; busy high for the same 6 cycles; GOOD_CNT=1.
REQ-032 Same packet with CSUM=0x00 -> error pulses 1 cycle; no outp_valid; ERR_CNT=1, RX_CNT=1.
REQ-033 Input 05,01,AA,AE (DA>=4) -> error pulse; ERR_CNT=1. Write CTRL=0xB, then send a valid DA=2 packet -> rejected.
REQ-034 Send 3 bytes while forwarding a LEN=3 packet -> DROP_CNT=3; forwarded bytes are unchanged.
REQ-035 Assert reset during the 3rd forwarded byte -> outp_valid=0 immediately; all CSRs read 0 except CTRL=0xF and INFO=0x0420.
REQ-036 Read 0x14 -> rdata=0x00000420 one cycle after rd. Write 0x00 in the same cycle as an RX increment -> RX_CNT reads 0.
